// File: rtl/prng_pkg.sv
// ---------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the xorshift pseudo-random generators.
//   - prngState_e : stream controller states (IDLE / RUN / DONE)
//   - DEFAULT_SEED_32 / DEFAULT_SEED_64 : non-zero reset seeds
//   - SH32_* / SH64_* : standard xorshift shift triples for 32 and 64 bits
// ---------------------------------------------------------------------------
package prng_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } prngState_e;

   localparam logic [31:0] DEFAULT_SEED_32 = 32'h92D68CA2;
   localparam logic [63:0] DEFAULT_SEED_64 = 64'h9E3779B97F4A7C15;

   localparam int SH32_A = 13;
   localparam int SH32_B = 17;
   localparam int SH32_C = 5;

   localparam int SH64_A = 13;
   localparam int SH64_B = 7;
   localparam int SH64_C = 17;

endpackage

// File: rtl/xorshift_step.sv
// ---------------------------------------------------------------------------
// xorshift_step
// Purely combinational xorshift step: o_next = next(i_x). Kept separate so
// multi-lane generators can instantiate one step per lane.
// Ports:
//   i_x    [WIDTH-1:0]  current generator state
//   o_next [WIDTH-1:0]  state after one xorshift step
// ---------------------------------------------------------------------------
module xorshift_step
   import prng_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SH_A  = SH32_A,
   parameter int SH_B  = SH32_B,
   parameter int SH_C  = SH32_C
) (
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_next
);

   logic [WIDTH-1:0] w_t1;
   logic [WIDTH-1:0] w_t2;

   // Three xor-shift stages; every shift drops bits that fall off the word,
   // so all intermediate values are naturally truncated to WIDTH.
   assign w_t1   = i_x  ^ (i_x  << SH_A);
   assign w_t2   = w_t1 ^ (w_t1 >> SH_B);
   assign o_next = w_t2 ^ (w_t2 << SH_C);

endmodule

// File: rtl/xorshift_prng_stream.sv
// ---------------------------------------------------------------------------
// xorshift_prng_stream
// Xorshift pseudo-random generator presented as a valid/ready stream with
// seed loading, zero-seed guard, burst / free-running modes and back-pressure.
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   seed_load   load seed (IDLE only); a zero seed loads DEFAULT_SEED
//   seed        seed value
//   start       begin a burst (IDLE only)
//   count       burst length sampled at start; 0 = free-running
//   stop        abort a running burst
//   rand_valid  rand_data holds a word for the consumer
//   rand_ready  consumer accepts the current word
//   rand_data   current random word (the state register itself)
//   busy        high while a burst is running
//   done        one-cycle pulse when a burst ends or is stopped
// ---------------------------------------------------------------------------
module xorshift_prng_stream
   import prng_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               SH_A         = SH32_A,
   parameter int               SH_B         = SH32_B,
   parameter int               SH_C         = SH32_C,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(DEFAULT_SEED_32),
   parameter int               CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             stop,
   output logic             rand_valid,
   input  logic             rand_ready,
   output logic [WIDTH-1:0] rand_data,
   output logic             busy,
   output logic             done
);

   prngState_e       r_fsm;
   prngState_e       w_fsmNext;
   logic [WIDTH-1:0] r_state;
   logic [CNT_W-1:0] r_remaining;
   logic             r_freeRun;

   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_seedGuarded;
   logic             w_handshake;
   logic             w_lastWord;

   xorshift_step #(
      .WIDTH (WIDTH),
      .SH_A  (SH_A),
      .SH_B  (SH_B),
      .SH_C  (SH_C)
   ) u_step (
      .i_x    (r_state),
      .o_next (w_next)
   );

   // A zero state is a fixed point of xorshift, so a zero seed is replaced
   // by the default seed; this keeps the state non-zero forever.
   assign w_seedGuarded = (seed == '0) ? DEFAULT_SEED : seed;

   // A word is transferred whenever we present one and the consumer takes it.
   // The last word only exists in counted bursts; free-running ignores the
   // counter entirely so it can never wrap into an accidental end.
   assign w_handshake = (r_fsm == RUN) && rand_ready;
   assign w_lastWord  = w_handshake && !r_freeRun && (r_remaining == CNT_W'(1));

   // Controller state register. Reset is asynchronous so rand_valid, which
   // decodes straight from this register, drops the moment reset rises.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsmNext;
      end
   end

   // Next-state logic. stop wins over everything in RUN; DONE always lasts
   // exactly one cycle before returning to IDLE.
   always_comb begin
      w_fsmNext = r_fsm;
      case (r_fsm)
         IDLE: begin
            if (start) begin
               w_fsmNext = RUN;
            end
         end
         RUN: begin
            if (stop || w_lastWord) begin
               w_fsmNext = DONE;
            end
         end
         DONE: begin
            w_fsmNext = IDLE;
         end
         default: begin
            w_fsmNext = IDLE;
         end
      endcase
   end

   // Generator state and burst bookkeeping. Seeding and burst setup are only
   // honoured in IDLE (both may happen in the same cycle, so the first word
   // of the burst is the freshly loaded seed). In RUN the state only advances
   // on a handshake, which keeps rand_data stable under back-pressure; a
   // handshake coinciding with stop still advances the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= DEFAULT_SEED;
         r_remaining <= '0;
         r_freeRun   <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (seed_load) begin
                  r_state <= w_seedGuarded;
               end
               if (start) begin
                  r_remaining <= count;
                  r_freeRun   <= (count == '0);
               end
            end
            RUN: begin
               if (w_handshake) begin
                  r_state <= w_next;
                  if (!r_freeRun) begin
                     r_remaining <= r_remaining - CNT_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state: no combinational path
   // from any input to valid/busy/done.
   assign rand_valid = (r_fsm == RUN);
   assign busy       = (r_fsm == RUN);
   assign done       = (r_fsm == DONE);
   assign rand_data  = r_state;

endmodule

// File: doc/xorshift_prng_stream.md
Name: xorshift_prng_stream

Overview:
Parametrised xorshift pseudo-random generator with a valid/ready output stream. It adds seed loading, a zero-seed guard, burst/free-running modes and back-pressure. It feeds randomised stimulus and measurement-basis selection to the quantum-emulation datapath. It replaces fixed-width, always-running generators.

Parameters:
WIDTH, 32, state/output width; legal values are 32 or 64.
SH_A, 13, first left-shift amount (use 13 for 64-bit).
SH_B, 17, right-shift amount (use 7 for 64-bit).
SH_C, 5, second left-shift amount (use 17 for 64-bit).
DEFAULT_SEED, 32'h92D68CA2 (zero-extended to WIDTH), reset seed and substitute for a zero seed.
CNT_W, 16, width of the burst-length counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
seed_load  input  1  load seed; honoured only in IDLE
seed  input  WIDTH  seed value
start  input  1  begin a burst; honoured only in IDLE
count  input  CNT_W  burst length sampled at start; 0 = free-running
stop  input  1  abort RUN; takes effect next cycle
rand_valid  output  1  rand_data is valid
rand_ready  input  1  consumer accepts the word
rand_data  output  WIDTH  current random word (the state register)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a burst ends or is stopped

Behaviour:
- Reset (asynchronous, active-high): state=DEFAULT_SEED, FSM=IDLE, remaining=0, rand_valid=0, busy=0, done=0. rand_data shows state, so it reads DEFAULT_SEED.
- Step function next(x), all operations truncated to WIDTH:
  - t = x ^ (x << SH_A)
  - t = t ^ (t >> SH_B)
  - result = t ^ (t << SH_C)
- Zero-seed guard: seed_load with seed==0 loads DEFAULT_SEED. State can never become 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_load: state<=seed (or the guarded value) next cycle.
  - start: remaining<=count, go to RUN.
  - seed_load and start together: both are accepted. The first RUN output is the loaded seed.
- RUN:
  - rand_valid=1, busy=1. rand_valid rises the cycle after start (1-cycle latency).
  - Handshake: on rand_valid&&rand_ready, state<=next(state). If count!=0, remaining decrements.
  - Without ready, rand_data and rand_valid hold stable (AXI-stream rule). valid never drops without a handshake, except on stop or reset.
  - If count!=0 and the handshake consumes the last word (remaining==1): go to DONE. Exactly count words are transferred.
  - If count==0: never ends on its own. remaining is ignored and does not wrap.
  - stop: go to DONE next cycle. A handshake in the same cycle as stop still completes and advances state.
  - seed_load and start are ignored in RUN.
- DONE: done=1, rand_valid=0, then IDLE. Lasts exactly one cycle; seed_load and start are ignored here.
- State persists across bursts. A new start continues the sequence unless re-seeded.
- Reset during RUN: immediate return to reset values; rand_valid drops asynchronously.

Decomposition:
- Shared package (prng_pkg): FSM state enum (IDLE/RUN/DONE); constants DEFAULT_SEED_32=32'h92D68CA2, DEFAULT_SEED_64=64'h9E3779B97F4A7C15; standard shift triples (13,17,5) and (13,7,17).
- Sub-module xorshift_step: purely combinational next(x), parametrised by WIDTH and the shift amounts. It is reused by future multi-lane generators.

Test Plan:
- Reset, then seed_load seed=1, start count=3, rand_ready=1 -> words 0x00000001, 0x00042021, 0x04080601, then a done pulse; busy low afterwards.
- seed_load seed=0, start count=1 -> single word 0x92D68CA2 (guard applied).
- Seed 1, count=2, rand_ready low for 4 cycles after valid -> rand_data held at 0x00000001 with valid high throughout; the 2 words are then delivered in order.
- count=0, ready=1, stop asserted after 5 handshakes -> 5 words accepted, a done pulse next cycle, rand_valid=0; a following start continues the sequence from the 6th value.
- Assert seed_load/start mid-RUN -> no effect on the sequence. Assert reset mid-RUN -> rand_valid=0 immediately, rand_data=0x92D68CA2.
- WIDTH=64 with shifts 13/7/17, seed 1, count=2 -> words 1, then next(1) matching a software model; no zero state over 10^5 steps.
